// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned ITERS = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Per-cycle shift-add / restoring shift-subtract datapath with iteration counter.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_op,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int unsigned CntW = $clog2(ITERS);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
  logic [CntW-1:0]  cnt_q;
  logic             div_q;
  logic [WIDTH:0]   add_sum, shifted, trial;

  // hi holds the upper product / partial remainder; lo the multiplier / quotient.
  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    shifted = {hi_q, lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (!div_q) begin
      hi_d = add_sum[WIDTH:1];
      lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      hi_d = trial[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = shifted[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= mag_a;
      b_q   <= mag_b;
      div_q <= div_op;
      cnt_q <= CntW'(ITERS - 1);
    end else if (step) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Optional macro MULDIV_DIVZERO_FASTPATH_EN: divide by zero completes straight from IDLE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e             state_q, state_d;
  logic [2:0]         f3_q;
  logic [WIDTH-1:0]   a_q, result_q, result_bak_q, fix_val;
  logic               neg_a_q, neg_b_q, b_zero_q;
  logic               sgn_a, sgn_b, accept, fast_zero, core_last;
  logic [WIDTH-1:0]   mag_a, mag_b, core_hi, core_lo, quo, rem;
  logic [2*WIDTH-1:0] prod;

  assign sgn_a = op_a[WIDTH-1] && (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
  assign sgn_b = op_b[WIDTH-1] && (funct3 inside {F3_MULH, F3_DIV, F3_REM});
  assign mag_a = sgn_a ? (~op_a + WIDTH'(1)) : op_a;
  assign mag_b = sgn_b ? (~op_b + WIDTH'(1)) : op_b;

  assign accept = (state_q == StIdle) && start;
`ifdef MULDIV_DIVZERO_FASTPATH_EN
  assign fast_zero = is_div(funct3) && (op_b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && !fast_zero),
    .step   (state_q == StCalc),
    .div_op (is_div(funct3)),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .hi     (core_hi),
    .lo     (core_lo),
    .last   (core_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = fast_zero ? StDone : StCalc;
      StCalc: if (flush) state_d = StIdle; else if (core_last) state_d = StFix;
      StFix:  state_d = flush ? StIdle : StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sign fix-up; 0x80000000 / -1 falls out of the magnitude path unaided.
  always_comb begin
    prod = {core_hi, core_lo};
    if (neg_a_q ^ neg_b_q) prod = ~prod + 1'b1;
    quo = (neg_a_q ^ neg_b_q) ? (~core_lo + WIDTH'(1)) : core_lo;
    rem = neg_a_q ? (~core_hi + WIDTH'(1)) : core_hi;
    if (b_zero_q) begin
      quo = '1;
      rem = a_q;
    end
    fix_val = '0;
    unique case (f3_q)
      F3_MUL:                       fix_val = prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              fix_val = quo;
      F3_REM, F3_REMU:              fix_val = rem;
      default:                      fix_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      f3_q         <= '0;
      a_q          <= '0;
      neg_a_q      <= 1'b0;
      neg_b_q      <= 1'b0;
      b_zero_q     <= 1'b0;
      result_q     <= '0;
      result_bak_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q     <= funct3;
        a_q      <= op_a;
        neg_a_q  <= sgn_a;
        neg_b_q  <= sgn_b;
        b_zero_q <= is_div(funct3) && (op_b == '0);
      end
      if (state_q == StFix && !flush) begin
        result_q     <= fix_val;
        result_bak_q <= result_q;
      end
`ifdef MULDIV_DIVZERO_FASTPATH_EN
      if (accept && fast_zero) begin
        result_q     <= funct3[1] ? op_a : '1;
        result_bak_q <= result_q;
      end
`endif
      // A flush in DONE retracts the just-written result.
      if (state_q == StDone && flush) result_q <= result_bak_q;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone) && !flush;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_res = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ev: 0 none, 1 stray start, 2 flush, 3 reset; applied during cycle N+ev_k.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int ev, input int ev_k, input string tag);
    int lat, done_at, done_cnt, busy_cnt, exp_busy, exp_done_at, exp_done_cnt;
    lat = 34;
`ifdef MULDIV_DIVZERO_FASTPATH_EN
    if (f[2] && b == 0) lat = 1;
`endif
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    done_at = -1; done_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == ev_k) begin
        if (ev == 1) start = 1'b1;
        if (ev == 2) flush = 1'b1;
        if (ev == 3) rst = 1'b1;
      end
      @(posedge clk); #1;
    end
    exp_busy = lat; exp_done_at = lat; exp_done_cnt = 1;
    if (ev == 2 || ev == 3) begin
      exp_busy = ev_k; exp_done_at = -1; exp_done_cnt = 0;
      if (ev == 3) model_res = '0;
    end else begin
      model_res = ref_op(f, a, b);
    end
    check({tag, ".latency"}, 64'(done_at), 64'(exp_done_at));
    check({tag, ".done_cnt"}, 64'(done_cnt), 64'(exp_done_cnt));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check({tag, ".result"}, 64'(result), 64'(model_res));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    check("reset.result", 64'(result), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 0, 0, "mul");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 0, 0, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         0, 0, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         0, 0, "rem_neg");
    run_op(3'd5, 32'd100,        32'd7,         0, 0, "divu");
    run_op(3'd7, 32'd100,        32'd7,         0, 0, "remu");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0, "rem_ovf");
    run_op(3'd4, 32'd5,          32'd0,         0, 0, "div_zero");
    run_op(3'd7, 32'd5,          32'd0,         0, 0, "remu_zero");
    run_op(3'd6, 32'hFFFF_FFF0,  32'd0,         0, 0, "rem_zero_neg");
    run_op(3'd1, 32'h1234_5678,  32'h9ABC_DEF0, 2, 10, "flush");
    run_op(3'd0, 32'd3,          32'd5,         1, 5, "stray_start");
    run_op(3'd5, 32'hDEAD_BEEF,  32'd3,         3, 20, "reset_mid");

    for (int i = 0; i < 30; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb, 0, 0, $sformatf("rand%0d_f%0d", i, rf));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
